// File: rtl/uart_frame_rx.sv
// uart_frame_rx: serial front end that recovers start + DATA_W payload + stop frames
// from an asynchronous idle-high line. The bit period is chosen per frame from baud_sel.
// Good payloads are presented on data with a one-cycle valid pulse.
// A high start bit is reported with a start_err pulse.
// A low stop bit is reported with a frame_err pulse.
module uart_frame_rx #(
  parameter int CLKS_FAST = 46880,
  parameter int CLKS_SLOW = 93760,
  parameter int DATA_W    = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in,
  input  logic              baud_sel,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              frame_err,
  output logic              start_err,
  output logic              busy
);

  localparam int CNT_W = $clog2(CLKS_SLOW);
  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  // Terminal counts: full bit period and half period (mid-bit of the start bit).
  localparam logic [CNT_W-1:0] FAST_LAST = CNT_W'(CLKS_FAST - 1);
  localparam logic [CNT_W-1:0] SLOW_LAST = CNT_W'(CLKS_SLOW - 1);
  localparam logic [CNT_W-1:0] FAST_HALF = CNT_W'(CLKS_FAST / 2 - 1);
  localparam logic [CNT_W-1:0] SLOW_HALF = CNT_W'(CLKS_SLOW / 2 - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_START   = 3'd1,
    S_DATA    = 3'd2,
    S_STOP    = 3'd3,
    S_WAIT_HI = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic              sync1_q, sync1_d;
  logic              sync2_q, sync2_d;
  logic              line_prev_q, line_prev_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              sel_q, sel_d;
  logic              valid_q, valid_d;
  logic              frame_err_q, frame_err_d;
  logic              start_err_q, start_err_d;
  logic              busy_q, busy_d;

  logic [CNT_W-1:0]  cnt_last;
  logic [CNT_W-1:0]  cnt_half;
  logic              line_fall;

  // Synchroniser chain plus one more stage used only for falling-edge detection.
  always_comb begin
    sync1_d     = in;
    sync2_d     = sync1_q;
    line_prev_d = sync2_q;
  end

  // Period selection uses the rate latched when the frame started, never the live input.
  always_comb begin
    cnt_last  = sel_q ? SLOW_LAST : FAST_LAST;
    cnt_half  = sel_q ? SLOW_HALF : FAST_HALF;
    line_fall = line_prev_q & ~sync2_q;
  end

  // Frame FSM: next state, counters, shift register and result pulses.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    sel_d       = sel_q;
    valid_d     = 1'b0;
    frame_err_d = 1'b0;
    start_err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        idx_d = '0;
        if (line_fall) begin
          state_d = S_START;
          sel_d   = baud_sel;
        end
      end

      S_START: begin
        if (cnt_q == cnt_half) begin
          cnt_d = '0;
          if (!sync2_q) begin
            state_d = S_DATA;
            idx_d   = '0;
          end else begin
            // Line went back high before mid-start: treat as a glitch.
            start_err_d = 1'b1;
            state_d     = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_DATA: begin
        if (cnt_q == cnt_last) begin
          cnt_d   = '0;
          shift_d = {shift_q[DATA_W-2:0], sync2_q};
          if (idx_q == IDX_LAST) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_STOP: begin
        if (cnt_q == cnt_last) begin
          cnt_d = '0;
          if (sync2_q) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            // Keep the previous payload; wait for the line to recover so a
            // stuck-low line cannot look like a new start bit.
            frame_err_d = 1'b1;
            state_d     = S_WAIT_HI;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      S_WAIT_HI: begin
        if (sync2_q) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // All state, including the synchroniser, returns to idle-line values on reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      line_prev_q <= 1'b1;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      sel_q       <= 1'b0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      start_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      line_prev_q <= line_prev_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      sel_q       <= sel_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      start_err_q <= start_err_d;
      busy_q      <= busy_d;
    end
  end

  assign data      = data_q;
  assign valid     = valid_q;
  assign frame_err = frame_err_q;
  assign start_err = start_err_q;
  assign busy      = busy_q;

  // Result pulses are mutually exclusive and last a single cycle.
  a_onehot_pulses : assert property (@(posedge clk) disable iff (!rst)
    $onehot0({valid_q, frame_err_q, start_err_q}));
  a_valid_single  : assert property (@(posedge clk) disable iff (!rst)
    valid_q |=> !valid_q);
  a_ferr_single   : assert property (@(posedge clk) disable iff (!rst)
    frame_err_q |=> !frame_err_q);
  a_serr_single   : assert property (@(posedge clk) disable iff (!rst)
    start_err_q |=> !start_err_q);

endmodule

// File: tb/tb_uart_frame_rx.sv
// tb_uart_frame_rx: directed frames on the serial line.
// A frame-level timing model predicts pulses, busy and data for every cycle.
module tb_uart_frame_rx;

  localparam int CF = 8;
  localparam int CS = 16;
  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          in;
  logic          baud_sel;
  logic [DW-1:0] data;
  logic          valid;
  logic          frame_err;
  logic          start_err;
  logic          busy;

  uart_frame_rx #(.CLKS_FAST(CF), .CLKS_SLOW(CS), .DATA_W(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .in        (in),
    .baud_sel  (baud_sel),
    .data      (data),
    .valid     (valid),
    .frame_err (frame_err),
    .start_err (start_err),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Model of the current frame, in clock-edge numbers.
  // ev_kind: 0 none, 1 valid, 2 frame_err, 3 start_err.
  int            ev_kind   = 0;
  int            ev_cyc    = -1;
  int            busy_from = -1;
  int            busy_to   = -1;
  logic [DW-1:0] d_old     = '0;
  logic [DW-1:0] d_new     = '0;
  int            fall_n    = 0;

  int total = 0;
  int bad   = 0;
  int n_v = 0, n_f = 0, n_s = 0, n_b = 0;
  int last_v_cyc = -1;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  // Per-cycle comparison against the model, 1 time unit after each active edge.
  always @(posedge clk) begin
    #1;
    if (!rst) begin
      chk("rst_data", int'(data), 0);
      chk("rst_valid", int'(valid), 0);
      chk("rst_ferr", int'(frame_err), 0);
      chk("rst_serr", int'(start_err), 0);
      chk("rst_busy", int'(busy), 0);
    end else begin
      chk("valid", int'(valid), int'(ev_kind == 1 && cyc == ev_cyc));
      chk("frame_err", int'(frame_err), int'(ev_kind == 2 && cyc == ev_cyc));
      chk("start_err", int'(start_err), int'(ev_kind == 3 && cyc == ev_cyc));
      chk("busy", int'(busy), int'(cyc >= busy_from && cyc < busy_to));
      chk("data", int'(data), int'((ev_kind == 1 && cyc >= ev_cyc) ? d_new : d_old));
      if (valid) begin
        n_v++;
        last_v_cyc = cyc;
      end
      if (frame_err) n_f++;
      if (start_err) n_s++;
      if (busy) n_b++;
    end
  end

  task automatic clear_model();
    ev_kind   = 0;
    ev_cyc    = -1;
    busy_from = -1;
    busy_to   = -1;
    d_old     = '0;
    d_new     = '0;
  endtask

  // Called on a negedge. The line falls before edge n+1 and is seen by the FSM at edge n+3.
  // The first sample is taken P/2 after that, then one sample every P.
  task automatic send_frame(input logic [DW-1:0] pay, input int p, input logic stop_b,
                            input int low_extra, input int flip_bit);
    logic [DW+1:0] bits;
    int n;
    bits      = {1'b0, pay, stop_b};
    n         = cyc;
    fall_n    = n;
    d_old     = d_new;
    ev_kind   = stop_b ? 1 : 2;
    ev_cyc    = n + 3 + p / 2 + 11 * p;
    d_new     = stop_b ? pay : d_old;
    busy_from = n + 3;
    busy_to   = stop_b ? ev_cyc : 32'h7fffffff;
    for (int b = DW + 1; b >= 0; b--) begin
      if (b == flip_bit) baud_sel = ~baud_sel;
      in = bits[b];
      repeat (p) @(negedge clk);
    end
    if (!stop_b) begin
      repeat (low_extra) @(negedge clk);
      in      = 1'b1;
      busy_to = cyc + 3;
    end
  endtask

  task automatic glitch(input int low_cycles);
    int n;
    n         = cyc;
    d_old     = d_new;
    ev_kind   = 3;
    ev_cyc    = n + 3 + CF / 2;
    busy_from = n + 3;
    busy_to   = ev_cyc;
    in = 1'b0;
    repeat (low_cycles) @(negedge clk);
    in = 1'b1;
  endtask

  int v0, f0, s0, b0, lat;

  initial begin
    rst      = 1'b0;
    in       = 1'b1;
    baud_sel = 1'b0;

    // 1: reset held with the line toggling
    repeat (7) begin
      @(negedge clk);
      in = ~in;
    end
    @(negedge clk);
    in = 1'b1;
    repeat (3) @(negedge clk);
    chk("t1_data", int'(data), 0);
    chk("t1_busy", int'(busy), 0);
    chk("t1_valid", int'(valid), 0);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    chk("t1_idle_busy", int'(busy), 0);

    // 2: fast frame, latency, then a back-to-back frame
    v0 = n_v; f0 = n_f; s0 = n_s;
    send_frame(10'b1010000111, CF, 1'b1, 0, -1);
    lat = last_v_cyc - (fall_n + 1);
    chk("t2_data", int'(data), int'(10'b1010000111));
    chk("t2_nvalid", n_v - v0, 1);
    chk("t2_latency_in_92_94", int'(lat >= 92 && lat <= 94), 1);
    send_frame(10'h2C5, CF, 1'b1, 0, -1);
    chk("t2_b2b_data", int'(data), int'(10'h2C5));
    chk("t2_errs", (n_f - f0) + (n_s - s0), 0);
    repeat (10) @(negedge clk);

    // 3: slow frame, then the same frame with baud_sel flipped mid-frame
    baud_sel = 1'b1;
    repeat (3) @(negedge clk);
    v0 = n_v;
    send_frame(10'b1000000001, CS, 1'b1, 0, -1);
    chk("t3_data", int'(data), int'(10'h201));
    repeat (5) @(negedge clk);
    send_frame(10'b1000000001, CS, 1'b1, 0, 6);
    chk("t3_flip_data", int'(data), int'(10'h201));
    chk("t3_nvalid", n_v - v0, 2);
    baud_sel = 1'b0;
    repeat (10) @(negedge clk);

    // 4: bad stop bit, line held low 5 more bit-times
    v0 = n_v; f0 = n_f; s0 = n_s;
    send_frame(10'h155, CF, 1'b0, 5 * CF, -1);
    repeat (12) @(negedge clk);
    chk("t4_data_kept", int'(data), int'(10'h201));
    chk("t4_nferr", n_f - f0, 1);
    chk("t4_nvalid", n_v - v0, 0);
    chk("t4_nserr", n_s - s0, 0);

    // 5: two-cycle glitch
    b0 = n_b; s0 = n_s;
    glitch(2);
    repeat (20) @(negedge clk);
    chk("t5_nserr", n_s - s0, 1);
    chk("t5_busy_cycles", n_b - b0, 4);

    // 6: reset in the middle of the payload, then a good frame
    v0 = n_v; f0 = n_f; s0 = n_s;
    fall_n    = cyc;
    d_old     = d_new;
    ev_kind   = 1;
    ev_cyc    = cyc + 3 + CF / 2 + 11 * CF;
    busy_from = cyc + 3;
    busy_to   = ev_cyc;
    in = 1'b0;
    repeat (CF) @(negedge clk);
    in = 1'b1;
    repeat (3 * CF) @(negedge clk);
    rst = 1'b0;
    clear_model();
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("t6_abort_data", int'(data), 0);
    chk("t6_abort_pulses", (n_v - v0) + (n_f - f0) + (n_s - s0), 0);
    send_frame(10'h3FF, CF, 1'b1, 0, -1);
    chk("t6_data", int'(data), int'(10'h3FF));
    chk("t6_nvalid", n_v - v0, 1);
    repeat (10) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
